// File: rtl/complex_mult_checker_if.sv
// Operand, result and status bundle between a complex multiplier stimulus source and its checker.
interface complex_mult_checker_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic                     clr;
   logic                     in_valid;
   logic signed [DATA_W-1:0] a1;
   logic signed [DATA_W-1:0] b1;
   logic signed [DATA_W-1:0] a2;
   logic signed [DATA_W-1:0] b2;
   logic signed [DATA_W-1:0] res_re;
   logic signed [DATA_W-1:0] res_im;
   logic                     cmp_valid;
   logic [CNT_W-1:0]         match_cnt;
   logic [CNT_W-1:0]         err_cnt;
   logic [1:0]               status;
   logic signed [DATA_W-1:0] err_exp_re;
   logic signed [DATA_W-1:0] err_exp_im;
   logic signed [DATA_W-1:0] err_got_re;
   logic signed [DATA_W-1:0] err_got_im;

   modport master (
      output clr, in_valid, a1, b1, a2, b2, res_re, res_im,
      input  cmp_valid, match_cnt, err_cnt, status,
      input  err_exp_re, err_exp_im, err_got_re, err_got_im
   );

   modport slave (
      input  clr, in_valid, a1, b1, a2, b2, res_re, res_im,
      output cmp_valid, match_cnt, err_cnt, status,
      output err_exp_re, err_exp_im, err_got_re, err_got_im
   );
endinterface

// File: rtl/complex_mult_checker.sv
// Complex multiplier result checker: compares res_re/res_im LATENCY cycles after each valid operand set.
// Fixed-latency pipe, one comparison per cycle, never stalls; clr flushes in-flight operands.
module complex_mult_checker #(
   parameter int DATA_W  = 8,
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   complex_mult_checker_if.slave bus
);
   localparam int FULL_W = 2 * DATA_W + 1;

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PASS = 2'b01,
      ST_FAIL = 2'b10
   } state_t;

   logic signed [FULL_W-1:0] a1_x, b1_x, a2_x, b2_x;
   logic signed [FULL_W-1:0] full_re, full_im;

   slot_t             slot_q [LATENCY];
   slot_t             slot_d [LATENCY];
   slot_t             head;
   logic              do_cmp;
   logic              is_match;
   logic [DATA_W-1:0] res_re_u, res_im_u;

   state_t            state_q, state_d;
   logic              cmp_valid_q, cmp_valid_d;
   logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0] exp_re_q, exp_re_d, exp_im_q, exp_im_d;
   logic [DATA_W-1:0] got_re_q, got_re_d, got_im_q, got_im_d;

   // Full-width reference so intermediate products never overflow before the final wrap.
   always_comb begin
      a1_x    = {{(DATA_W + 1){bus.a1[DATA_W-1]}}, bus.a1};
      b1_x    = {{(DATA_W + 1){bus.b1[DATA_W-1]}}, bus.b1};
      a2_x    = {{(DATA_W + 1){bus.a2[DATA_W-1]}}, bus.a2};
      b2_x    = {{(DATA_W + 1){bus.b2[DATA_W-1]}}, bus.b2};
      full_re = a1_x * a2_x - b1_x * b2_x;
      full_im = a1_x * b2_x + b1_x * a2_x;
   end

   always_comb begin
      slot_d[0].vld = bus.in_valid & ~bus.clr;
      slot_d[0].re  = full_re[DATA_W-1:0];
      slot_d[0].im  = full_im[DATA_W-1:0];
      for (int i = 1; i < LATENCY; i++) begin
         slot_d[i] = slot_q[i-1];
      end
      if (bus.clr) begin
         for (int i = 0; i < LATENCY; i++) begin
            slot_d[i].vld = 1'b0;
         end
      end
   end

   assign head     = slot_q[LATENCY-1];
   assign res_re_u = bus.res_re;
   assign res_im_u = bus.res_im;
   assign do_cmp   = head.vld & ~bus.clr;
   assign is_match = (head.re == res_re_u) && (head.im == res_im_u);

   always_comb begin
      state_d     = state_q;
      cmp_valid_d = do_cmp;
      match_cnt_d = match_cnt_q;
      err_cnt_d   = err_cnt_q;
      exp_re_d    = exp_re_q;
      exp_im_d    = exp_im_q;
      got_re_d    = got_re_q;
      got_im_d    = got_im_q;
      if (bus.clr) begin
         state_d     = ST_IDLE;
         match_cnt_d = '0;
         err_cnt_d   = '0;
         exp_re_d    = '0;
         exp_im_d    = '0;
         got_re_d    = '0;
         got_im_d    = '0;
      end else if (do_cmp) begin
         if (is_match) begin
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_W'(1);
            if (state_q == ST_IDLE) state_d = ST_PASS;
         end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            // Only the first mismatch is kept; FAIL is sticky so later ones skip this.
            if (state_q != ST_FAIL) begin
               state_d  = ST_FAIL;
               exp_re_d = head.re;
               exp_im_d = head.im;
               got_re_d = res_re_u;
               got_im_d = res_im_u;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            slot_q[i] <= '0;
         end
         state_q     <= ST_IDLE;
         cmp_valid_q <= 1'b0;
         match_cnt_q <= '0;
         err_cnt_q   <= '0;
         exp_re_q    <= '0;
         exp_im_q    <= '0;
         got_re_q    <= '0;
         got_im_q    <= '0;
      end else begin
         slot_q      <= slot_d;
         state_q     <= state_d;
         cmp_valid_q <= cmp_valid_d;
         match_cnt_q <= match_cnt_d;
         err_cnt_q   <= err_cnt_d;
         exp_re_q    <= exp_re_d;
         exp_im_q    <= exp_im_d;
         got_re_q    <= got_re_d;
         got_im_q    <= got_im_d;
      end
   end

   assign bus.cmp_valid  = cmp_valid_q;
   assign bus.match_cnt  = match_cnt_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.status     = state_q;
   assign bus.err_exp_re = exp_re_q;
   assign bus.err_exp_im = exp_im_q;
   assign bus.err_got_re = got_re_q;
   assign bus.err_got_im = got_im_q;
endmodule

// File: tb/tb_complex_mult_checker.sv
// Bench for complex_mult_checker: three instances (latency 1, 4, and 2 with 3-bit counters) against a queue-based model.
module tb_complex_mult_checker;
   typedef struct {
      int         due;
      logic [7:0] re;
      logic [7:0] im;
   } pend_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_nxt = 1'b1;
   always #5 clk = ~clk;

   logic              clr_b = 1'b0, vld_b = 1'b0;
   logic signed [7:0] a1_b = '0, b1_b = '0, a2_b = '0, b2_b = '0;
   logic [7:0]        res_re_b [3];
   logic [7:0]        res_im_b [3];

   logic        dut_cmp [3];
   logic [15:0] dut_match [3], dut_err [3];
   logic [1:0]  dut_status [3];
   logic [7:0]  dut_xr [3], dut_xi [3], dut_gr [3], dut_gi [3];

   int lat [3]  = '{1, 4, 2};
   int cmax [3] = '{65535, 65535, 7};

   // Behavioural model state
   pend_t      pend [3][$];
   logic       m_cmp [3];
   int         m_match [3], m_err [3], m_status [3];
   logic [7:0] m_xr [3], m_xi [3], m_gr [3], m_gi [3];
   logic [7:0] hist_re [3][8];
   logic [7:0] hist_im [3][8];

   int n_cmp = 0, n_bad = 0, edge_cnt = 0;
   int armed = 0, arm_edge = 0;
   int first_cmp [3] = '{-1, -1, -1};

   complex_mult_checker_if #(.DATA_W(8), .CNT_W(16)) if0 ();
   complex_mult_checker_if #(.DATA_W(8), .CNT_W(16)) if1 ();
   complex_mult_checker_if #(.DATA_W(8), .CNT_W(3))  if2 ();

   complex_mult_checker #(.DATA_W(8), .LATENCY(1), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   complex_mult_checker #(.DATA_W(8), .LATENCY(4), .CNT_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   complex_mult_checker #(.DATA_W(8), .LATENCY(2), .CNT_W(3))  u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   assign if0.clr = clr_b;  assign if0.in_valid = vld_b;
   assign if0.a1 = a1_b;    assign if0.b1 = b1_b;  assign if0.a2 = a2_b;  assign if0.b2 = b2_b;
   assign if0.res_re = res_re_b[0];  assign if0.res_im = res_im_b[0];
   assign if1.clr = clr_b;  assign if1.in_valid = vld_b;
   assign if1.a1 = a1_b;    assign if1.b1 = b1_b;  assign if1.a2 = a2_b;  assign if1.b2 = b2_b;
   assign if1.res_re = res_re_b[1];  assign if1.res_im = res_im_b[1];
   assign if2.clr = clr_b;  assign if2.in_valid = vld_b;
   assign if2.a1 = a1_b;    assign if2.b1 = b1_b;  assign if2.a2 = a2_b;  assign if2.b2 = b2_b;
   assign if2.res_re = res_re_b[2];  assign if2.res_im = res_im_b[2];

   assign dut_cmp[0] = if0.cmp_valid;  assign dut_match[0] = if0.match_cnt;
   assign dut_err[0] = if0.err_cnt;    assign dut_status[0] = if0.status;
   assign dut_xr[0] = if0.err_exp_re;  assign dut_xi[0] = if0.err_exp_im;
   assign dut_gr[0] = if0.err_got_re;  assign dut_gi[0] = if0.err_got_im;
   assign dut_cmp[1] = if1.cmp_valid;  assign dut_match[1] = if1.match_cnt;
   assign dut_err[1] = if1.err_cnt;    assign dut_status[1] = if1.status;
   assign dut_xr[1] = if1.err_exp_re;  assign dut_xi[1] = if1.err_exp_im;
   assign dut_gr[1] = if1.err_got_re;  assign dut_gi[1] = if1.err_got_im;
   assign dut_cmp[2] = if2.cmp_valid;  assign dut_match[2] = {13'b0, if2.match_cnt};
   assign dut_err[2] = {13'b0, if2.err_cnt};  assign dut_status[2] = if2.status;
   assign dut_xr[2] = if2.err_exp_re;  assign dut_xi[2] = if2.err_exp_im;
   assign dut_gr[2] = if2.err_got_re;  assign dut_gi[2] = if2.err_got_im;

   function automatic logic [15:0] golden(input int x1, input int y1, input int x2, input int y2);
      int re, im;
      re = x1 * x2 - y1 * y2;
      im = x1 * y2 + y1 * x2;
      return {re[7:0], im[7:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic model_reset(input int i);
      pend[i].delete();
      m_cmp[i] = 1'b0; m_match[i] = 0; m_err[i] = 0; m_status[i] = 0;
      m_xr[i] = '0; m_xi[i] = '0; m_gr[i] = '0; m_gi[i] = '0;
   endtask

   task automatic model_step(input int i);
      pend_t p;
      logic [15:0] g;
      if (!rst_n || clr_b) begin
         model_reset(i);
         return;
      end
      m_cmp[i] = 1'b0;
      if (pend[i].size() > 0 && pend[i][0].due == edge_cnt) begin
         p = pend[i].pop_front();
         m_cmp[i] = 1'b1;
         if (p.re == res_re_b[i] && p.im == res_im_b[i]) begin
            if (m_match[i] < cmax[i]) m_match[i]++;
            if (m_status[i] == 0) m_status[i] = 1;
         end else begin
            if (m_err[i] < cmax[i]) m_err[i]++;
            if (m_status[i] != 2) begin
               m_status[i] = 2;
               m_xr[i] = p.re; m_xi[i] = p.im;
               m_gr[i] = res_re_b[i]; m_gi[i] = res_im_b[i];
            end
         end
      end
      if (vld_b) begin
         g = golden(a1_b, b1_b, a2_b, b2_b);
         p.due = edge_cnt + lat[i];
         p.re = g[15:8];
         p.im = g[7:0];
         pend[i].push_back(p);
      end
   endtask

   // Model update on the edge, DUT comparison 2 time units later.
   always @(posedge clk) begin
      logic [15:0] g;
      edge_cnt++;
      for (int i = 0; i < 3; i++) model_step(i);
      g = golden(a1_b, b1_b, a2_b, b2_b);
      for (int i = 0; i < 3; i++) begin
         for (int k = 7; k > 0; k--) begin
            hist_re[i][k] = hist_re[i][k-1];
            hist_im[i][k] = hist_im[i][k-1];
         end
         hist_re[i][0] = g[15:8];
         hist_im[i][0] = g[7:0];
      end
      #2;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.cmp_valid@%0d", i, edge_cnt), 32'(dut_cmp[i]), 32'(m_cmp[i]));
         chk($sformatf("u%0d.match_cnt@%0d", i, edge_cnt), 32'(dut_match[i]), m_match[i]);
         chk($sformatf("u%0d.err_cnt@%0d", i, edge_cnt), 32'(dut_err[i]), m_err[i]);
         chk($sformatf("u%0d.status@%0d", i, edge_cnt), 32'(dut_status[i]), m_status[i]);
         chk($sformatf("u%0d.err_exp_re@%0d", i, edge_cnt), 32'(dut_xr[i]), 32'(m_xr[i]));
         chk($sformatf("u%0d.err_exp_im@%0d", i, edge_cnt), 32'(dut_xi[i]), 32'(m_xi[i]));
         chk($sformatf("u%0d.err_got_re@%0d", i, edge_cnt), 32'(dut_gr[i]), 32'(m_gr[i]));
         chk($sformatf("u%0d.err_got_im@%0d", i, edge_cnt), 32'(dut_gi[i]), 32'(m_gi[i]));
         if (armed != 0 && first_cmp[i] < 0 && dut_cmp[i] === 1'b1) first_cmp[i] = edge_cnt;
      end
   end

   task automatic drv(input logic v, input int x1, input int y1, input int x2, input int y2,
                      input logic c, input logic oe, input int ore, input int oim);
      @(negedge clk);
      rst_n = rst_nxt;
      vld_b = v;
      clr_b = c;
      a1_b = x1[7:0]; b1_b = y1[7:0]; a2_b = x2[7:0]; b2_b = y2[7:0];
      for (int i = 0; i < 3; i++) begin
         if (oe) begin
            res_re_b[i] = ore[7:0];
            res_im_b[i] = oim[7:0];
         end else begin
            res_re_b[i] = hist_re[i][lat[i]-1];
            res_im_b[i] = hist_im[i][lat[i]-1];
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic op(input int x1, input int y1, input int x2, input int y2);
      drv(1'b1, x1, y1, x2, y2, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic ovr(input int re, input int im);
      drv(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, re, im);
   endtask

   task automatic clr_pulse();
      drv(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         res_re_b[i] = '0; res_im_b[i] = '0;
         model_reset(i);
         for (int k = 0; k < 8; k++) begin
            hist_re[i][k] = '0; hist_im[i][k] = '0;
         end
      end
      rst_nxt = 1'b0;
      idle(3);
      rst_nxt = 1'b1;

      // Idle after reset
      idle(20);
      chk("idle.match_cnt", 32'(dut_match[0]), 0);
      chk("idle.err_cnt", 32'(dut_err[0]), 0);
      chk("idle.status", 32'(dut_status[0]), 0);

      // (-2+4j)*(3-7j) = 22+26j, every third cycle, correct results
      for (int s = 0; s < 10; s++) begin
         op(-2, 4, 3, -7);
         idle(2);
      end
      idle(5);
      chk("pass10.match_cnt", 32'(dut_match[0]), 10);
      chk("pass10.err_cnt", 32'(dut_err[0]), 0);
      chk("pass10.status", 32'(dut_status[0]), 1);
      chk("pass10.sat_match_cnt", 32'(dut_match[2]), 7);

      // 100*100 = 10000 wraps to 0x10
      clr_pulse();
      op(100, 0, 100, 0);
      idle(3);
      chk("ovf.match_cnt", 32'(dut_match[0]), 1);
      chk("ovf.status_pass", 32'(dut_status[0]), 1);
      op(100, 0, 100, 0);
      ovr(127, 0);
      idle(3);
      chk("ovf.err_cnt", 32'(dut_err[0]), 1);
      chk("ovf.status_fail", 32'(dut_status[0]), 2);
      chk("ovf.err_exp_re", 32'(dut_xr[0]), 16);
      chk("ovf.err_got_re", 32'(dut_gr[0]), 127);

      // Two mismatches: capture keeps only the first
      clr_pulse();
      op(-2, 4, 3, -7);
      ovr(22, 25);
      op(1, 1, 1, 4);
      ovr(0, 0);
      idle(3);
      chk("two.err_cnt", 32'(dut_err[0]), 2);
      chk("two.err_exp_re", 32'(dut_xr[0]), 22);
      chk("two.err_exp_im", 32'(dut_xi[0]), 26);
      chk("two.err_got_re", 32'(dut_gr[0]), 22);
      chk("two.err_got_im", 32'(dut_gi[0]), 25);

      // clr with one operand in flight, then clr coinciding with in_valid
      op(-2, 4, 3, -7);
      clr_pulse();
      idle(4);
      chk("clr.match_cnt", 32'(dut_match[0]), 0);
      chk("clr.err_cnt", 32'(dut_err[0]), 0);
      chk("clr.status", 32'(dut_status[0]), 0);
      drv(1'b1, -2, 4, 3, -7, 1'b1, 1'b0, 0, 0);
      idle(6);
      chk("clr_vld.match_cnt", 32'(dut_match[0]), 0);
      chk("clr_vld.match_cnt_l4", 32'(dut_match[1]), 0);

      // Latency sweep: 50 back-to-back random operand sets, correct results
      clr_pulse();
      idle(6);
      armed = 1;
      for (int s = 0; s < 50; s++) begin
         op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
         if (s == 0) arm_edge = edge_cnt;
      end
      idle(6);
      armed = 0;
      chk("sweep.l1_first_cmp_delay", 32'(first_cmp[0] - arm_edge), 2);
      chk("sweep.l4_first_cmp_delay", 32'(first_cmp[1] - arm_edge), 5);
      chk("sweep.l1_match_cnt", 32'(dut_match[0]), 50);
      chk("sweep.l4_match_cnt", 32'(dut_match[1]), 50);
      chk("sweep.l4_status", 32'(dut_status[1]), 1);
      chk("sweep.sat_match_cnt", 32'(dut_match[2]), 7);

      // Random traffic with corrupted results, occasional clr and a mid-run reset
      for (int k = 0; k < 300; k++) begin
         rst_nxt = !(k >= 150 && k < 152);
         drv(1'($urandom_range(0, 1)),
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
             1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 255), $urandom_range(0, 255));
      end
      rst_nxt = 1'b1;
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
